// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types and constants for the stopwatch sequencer:
//            FSM state encoding, BCD digit geometry and per-digit moduli.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // FSM state encoding.
  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    COUNTING = 2'd1,
    IDLE     = 2'd2
  } state_t;

  // BCD digit geometry.
  localparam int c_digit_w    = 4;
  localparam int c_num_digits = 4;

  // Per-digit moduli, least significant digit first.
  localparam int c_mod_cs_ones  = 10;
  localparam int c_mod_cs_tens  = 10;
  localparam int c_mod_sec_ones = 10;
  localparam int c_mod_sec_tens = 10;

  // Modulus of digit position idx (0 = hundredths ones).
  function automatic int digit_mod(input int idx);
    case (idx)
      0:       digit_mod = c_mod_cs_ones;
      1:       digit_mod = c_mod_cs_tens;
      2:       digit_mod = c_mod_sec_ones;
      default: digit_mod = c_mod_sec_tens;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_seq_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One modulo-MOD BCD digit with synchronous clear and an
//            increment input; carry flags the wrap so digits can be chained.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] c_last = 4'(MOD - 1);

  // Digit register: clear wins over increment, wrap at MOD-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == c_last) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = inc & (q == c_last);

endmodule
`default_nettype wire

// File: rtl/stopwatch_seq.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_seq
// Purpose  : Stopwatch sequencer: trig/split FSM, 1/100 s prescaler,
//            4-digit BCD SS.cc counter and split-display freeze register.
// Options  : STOPWATCH_SATURATE_EN - saturate at 99.99 and force PAUSED
//            instead of wrapping to 00.00.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_seq
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int PRESC_W  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic        split,
  output logic        init_regs,
  output logic        count_enabled,
  output logic        tick,
  output logic [15:0] disp_bcd,
  output logic        frozen,
  output logic        overflow
);

  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICK_DIV - 1);

  state_t                r_state;
  state_t                w_fsm_next;
  state_t                w_state_next;
  logic                  w_trig;
  logic [PRESC_W-1:0]    r_presc;
  logic                  w_tick;
  logic                  w_count_inc;
  logic                  w_ovf_set;
  logic [c_num_digits:0] w_inc;
  logic [15:0]           w_live;
  logic [15:0]           r_snap;
  logic                  r_frozen;
  logic                  r_overflow;

`ifdef STOPWATCH_SATURATE_EN
  logic w_at_max;
  logic w_sat_stop;

  // A saturated count is parked in PAUSED; trig cannot restart it.
  assign w_at_max     = (w_live == 16'h9999);
  assign w_sat_stop   = w_tick & w_at_max;
  assign w_trig       = trig & ~((r_state == PAUSED) & r_overflow);
  assign w_count_inc  = w_tick & ~w_at_max;
  assign w_ovf_set    = w_sat_stop | w_inc[c_num_digits];
  assign w_state_next = w_sat_stop ? PAUSED : w_fsm_next;
`else
  assign w_trig       = trig;
  assign w_count_inc  = w_tick;
  assign w_ovf_set    = w_inc[c_num_digits];
  assign w_state_next = w_fsm_next;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Mealy datapath controls; trig takes priority over split.
  always_comb begin
    w_fsm_next    = r_state;
    init_regs     = 1'b0;
    count_enabled = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_fsm_next    = COUNTING;
          count_enabled = 1'b1;
        end else begin
          init_regs = 1'b1;
        end
      end
      COUNTING: begin
        if (w_trig) begin
          w_fsm_next = PAUSED;
        end else begin
          count_enabled = 1'b1;
        end
      end
      PAUSED: begin
        if (w_trig) begin
          w_fsm_next    = COUNTING;
          count_enabled = 1'b1;
        end else if (split) begin
          w_fsm_next = IDLE;
        end
      end
      default: begin
        w_fsm_next = IDLE;
        init_regs  = 1'b1;
      end
    endcase
    if (reset) begin
      init_regs     = 1'b1;
      count_enabled = 1'b0;
    end
  end

  assign w_tick = count_enabled & (r_presc == c_presc_last);
  assign tick   = w_tick;

  // Prescaler: phase survives PAUSED, cleared only by init_regs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (init_regs) begin
      r_presc <= '0;
    end else if (count_enabled) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  assign w_inc[0] = w_count_inc;

  for (genvar gi = 0; gi < c_num_digits; gi++) begin : g_digit
    bcd_digit #(
      .MOD (digit_mod(gi))
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (init_regs),
      .inc   (w_inc[gi]),
      .q     (w_live[gi*c_digit_w +: c_digit_w]),
      .carry (w_inc[gi+1])
    );
  end

  // Split freeze: only live while staying in COUNTING; snapshot is pre-update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frozen <= 1'b0;
      r_snap   <= 16'h0000;
    end else if ((r_state != COUNTING) || (w_state_next != COUNTING)) begin
      r_frozen <= 1'b0;
    end else if (split) begin
      if (!r_frozen) begin
        r_snap   <= w_live;
        r_frozen <= 1'b1;
      end else begin
        r_frozen <= 1'b0;
      end
    end
  end

  // Sticky overflow, cleared together with the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (init_regs) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end
  end

  assign disp_bcd = r_frozen ? r_snap : w_live;
  assign frozen   = r_frozen;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_seq
// Purpose  : Self-checking bench for stopwatch_seq: table of trig/split
//            vectors with hand-derived expectations (TICK_DIV=4), async
//            reset mid-count, and 99.99 rollover on a TICK_DIV=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_seq;

  typedef struct {
    logic        trig;
    logic        split;
    int          n;
    logic        e_init;
    logic        e_cen;
    logic        e_tick;
    logic [15:0] e_disp;
    logic        e_frz;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] disp;
    logic        frz;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset, trig, split;
  logic        init_regs, count_enabled, tick, frozen, overflow;
  logic [15:0] disp_bcd;

  logic        reset2, trig2, split2;
  logic        init2, cen2, tick2, frozen2, ovf2;
  logic [15:0] disp2;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[19];

  stopwatch_seq #(.TICK_DIV(4), .PRESC_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .trig          (trig),
    .split         (split),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .tick          (tick),
    .disp_bcd      (disp_bcd),
    .frozen        (frozen),
    .overflow      (overflow)
  );

  stopwatch_seq #(.TICK_DIV(1), .PRESC_W(1)) dut_fast (
    .clk           (clk),
    .reset         (reset2),
    .trig          (trig2),
    .split         (split2),
    .init_regs     (init2),
    .count_enabled (cen2),
    .tick          (tick2),
    .disp_bcd      (disp2),
    .frozen        (frozen2),
    .overflow      (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one vector for a cycle, check Mealy outputs, idle n cycles,
  // then pop the scoreboard and check the registered outputs.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    trig  = v.trig;
    split = v.split;
    #1;
    chk($sformatf("v%0d_init", idx), init_regs, v.e_init);
    chk($sformatf("v%0d_cen", idx), count_enabled, v.e_cen);
    chk($sformatf("v%0d_tick", idx), tick, v.e_tick);
    e.idx  = idx;
    e.disp = v.e_disp;
    e.frz  = v.e_frz;
    e.ovf  = v.e_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    trig  = 1'b0;
    split = 1'b0;
    repeat (v.n) begin
      @(posedge clk);
      #1;
    end
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty v%0d: got 0 entries expected 1", idx);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_disp", got.idx), disp_bcd, got.disp);
      chk($sformatf("v%0d_frozen", got.idx), frozen, got.frz);
      chk($sformatf("v%0d_ovf", got.idx), overflow, got.ovf);
    end
  endtask

  initial begin
    //              trig split n   init cen tick disp     frz  ovf
    tbl[0]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 40, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 19, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1,  0, 1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1,  0, 1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0,  0, 1'b0, 1'b1, 1'b1, 16'h0009, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1,  0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0,  5, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

    reset  = 1'b1;
    trig   = 1'b0;
    split  = 1'b0;
    reset2 = 1'b1;
    trig2  = 1'b0;
    split2 = 1'b0;

    // Reset state while reset is held.
    #3;
    chk("rst_init", init_regs, 1'b1);
    chk("rst_cen", count_enabled, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_disp", disp_bcd, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_frozen", frozen, 1'b0);

    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i], i);
    end

    // Asynchronous reset pulse of 2 ns, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_disp", disp_bcd, 16'h0000);
    chk("arst_init", init_regs, 1'b1);
    chk("arst_cen", count_enabled, 1'b0);
    #1;
    reset = 1'b0;
    apply(tbl[18], 18);

    // Rollover at 99.99 on the TICK_DIV=1 instance.
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    trig2  = 1'b1;
    #1;
    chk("fast_start_cen", cen2, 1'b1);
    chk("fast_start_tick", tick2, 1'b1);
    @(posedge clk);
    #1;
    trig2 = 1'b0;
    repeat (9998) @(posedge clk);
    #1;
    chk("fast_9999_disp", disp2, 16'h9999);
    chk("fast_9999_ovf", ovf2, 1'b0);
    @(posedge clk);
    #1;
`ifdef STOPWATCH_SATURATE_EN
    chk("sat_disp", disp2, 16'h9999);
    chk("sat_ovf", ovf2, 1'b1);
    chk("sat_init", init2, 1'b0);
    chk("sat_cen", cen2, 1'b0);
    trig2 = 1'b1;
    #1;
    chk("sat_trig_cen", cen2, 1'b0);
    @(posedge clk);
    #1;
    trig2 = 1'b0;
    #1;
    chk("sat_hold_disp", disp2, 16'h9999);
    chk("sat_hold_cen", cen2, 1'b0);
    split2 = 1'b1;
    @(posedge clk);
    #1;
    split2 = 1'b0;
    #1;
    chk("sat_idle_init", init2, 1'b1);
    @(posedge clk);
    #1;
    chk("sat_clear_ovf", ovf2, 1'b0);
    chk("sat_clear_disp", disp2, 16'h0000);
`else
    chk("wrap_disp", disp2, 16'h0000);
    chk("wrap_ovf", ovf2, 1'b1);
    chk("wrap_cen", cen2, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap_next_disp", disp2, 16'h0001);
    chk("wrap_sticky_ovf", ovf2, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
